ysyx_22041207_ifu: RTL

Instruction fetch unit: owns the PC, issues word fetches to instruction memory and presents each fetched instruction with its PC to the decoder over a valid/ready handshake. It sits between the instruction memory port and the decoder's `inst` input. It takes PC redirects (jal, jalr, taken branch, ecall, mret) from execute/writeback and discards all wrong-path fetches.

---
 rtl/ysyx_22041207_ifu_pkg.sv | 21 ++
 rtl/ysyx_22041207_pc_reg.sv | 38 +++
 rtl/ysyx_22041207_ifu.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ysyx_22041207_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and reset constants.
package ysyx_22041207_ifu_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StWait  = 3'd2,
        StDrain = 3'd3,
        StHold  = 3'd4
    } ifu_state_e;

    localparam logic [31:0] InstNop       = 32'h0000_0013;
    localparam logic [63:0] DefaultResetPc = 64'h0000_0000_8000_0000;
    localparam logic [63:0] PcStep        = 64'd4;

    // Forces a fetch address onto a word boundary.
    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return addr & ~64'h3;
    endfunction

endpackage

// File: rtl/ysyx_22041207_pc_reg.sv
// Program counter register: async reset, redirect load (highest priority) and +4 increment.
module ysyx_22041207_pc_reg
    import ysyx_22041207_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DefaultResetPc
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [63:0] load_pc_i,
    input  logic        incr_i,
    output logic [63:0] pc_o,
    output logic [63:0] pc_next_o
);

    logic [63:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = word_align(load_pc_i);
        end else if (incr_i) begin
            pc_d = pc_q + PcStep;  // wraps modulo 2^64
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_d;

endmodule

// File: rtl/ysyx_22041207_ifu.sv
// Instruction fetch unit: one outstanding word fetch, single-entry output buffer, redirect kill.
module ysyx_22041207_ifu
    import ysyx_22041207_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DefaultResetPc
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc
);

    ifu_state_e  state_d, state_q;
    logic        req_valid_d, req_valid_q;
    logic [63:0] req_addr_d, req_addr_q;
    logic        inst_valid_d, inst_valid_q;
    logic [31:0] inst_d, inst_q;
    logic [63:0] inst_pc_d, inst_pc_q;

    logic        pc_load;
    logic        pc_incr;
    logic [63:0] pc;
    logic [63:0] pc_next;

    ysyx_22041207_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (pc_load),
        .load_pc_i (redirect_pc),
        .incr_i    (pc_incr),
        .pc_o      (pc),
        .pc_next_o (pc_next)
    );

    always_comb begin
        state_d   = state_q;
        pc_load   = 1'b0;
        pc_incr   = 1'b0;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;

        if (redirect_valid) begin
            // Redirect beats every other event; a killed in-flight request must be drained.
            pc_load = 1'b1;
            unique case (state_q)
                StIdle:  state_d = StIdle;
                StReq:   state_d = imem_req_ready ? StDrain : StReq;
                StWait:  state_d = imem_rsp_valid ? StReq : StDrain;
                StDrain: state_d = imem_rsp_valid ? StReq : StDrain;
                StHold:  state_d = StReq;
                default: state_d = StIdle;
            endcase
        end else begin
            unique case (state_q)
                StIdle: state_d = StReq;
                StReq: begin
                    if (imem_req_ready) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (imem_rsp_valid) begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = pc;
                        pc_incr   = 1'b1;
                        state_d   = StHold;
                    end
                end
                StHold: begin
                    if (inst_ready) begin
                        state_d = StReq;
                    end
                end
                StDrain: begin
                    if (imem_rsp_valid) begin
                        state_d = StReq;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Outputs are registered copies of the next state so no input reaches a port directly.
        req_valid_d  = (state_d == StReq);
        req_addr_d   = pc_next;
        inst_valid_d = (state_d == StHold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            req_valid_q  <= 1'b0;
            req_addr_q   <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= InstNop;
            inst_pc_q    <= RESET_PC;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

endmodule
